// File: rtl/pe_tap_sequencer.sv
// Tap sequencer for one PE multiplier: walks window tap addresses into the
// operand buffers, strobes the PE, accumulates its products and hands the sum out.
module pe_tap_sequencer #(
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 20,
  parameter int ACC_WIDTH    = 24,
  parameter int MAX_TAPS     = 9,
  parameter int ADDR_WIDTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [7:0]                     num_taps,
  output logic                           busy,
  output logic                           buf_rd_en,
  output logic [ADDR_WIDTH-1:0]          buf_rd_addr,
  input  logic signed [INPUT_WIDTH-1:0]  ifm_rdata,
  input  logic signed [INPUT_WIDTH-1:0]  wgt_rdata,
  output logic                           pe_ready_load,
  output logic [INPUT_WIDTH-1:0]         pe_ifm,
  output logic [INPUT_WIDTH-1:0]         pe_wgt,
  input  logic signed [OUTPUT_WIDTH-1:0] pe_product,
  input  logic                           pe_ready_adder,
  output logic signed [ACC_WIDTH-1:0]    acc_out,
  output logic                           acc_valid,
  input  logic                           acc_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [7:0] MAX_N = 8'(MAX_TAPS);

  state_t                  state;
  logic [7:0]              n_lat;
  logic [7:0]              ret_cnt;
  logic [7:0]              ret_nxt;
  logic [ADDR_WIDTH-1:0]   tap_cnt;
  logic signed [ACC_WIDTH-1:0] acc;
  logic                    accum;
  logic [ACC_WIDTH-1:0]    prod_ext;

  assign busy        = (state != IDLE);
  assign buf_rd_addr = tap_cnt;
  assign acc_out     = acc;
  assign pe_ifm      = ifm_rdata;
  assign pe_wgt      = wgt_rdata;

  // Products only count while a window is in flight; stray pulses after an
  // abort land in IDLE and are dropped.
  assign accum    = pe_ready_adder && (state == ISSUE || state == DRAIN);
  assign ret_nxt  = ret_cnt + {7'd0, accum};
  assign prod_ext = {{(ACC_WIDTH-OUTPUT_WIDTH){pe_product[OUTPUT_WIDTH-1]}}, pe_product};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      n_lat         <= '0;
      ret_cnt       <= '0;
      tap_cnt       <= '0;
      acc           <= '0;
      buf_rd_en     <= 1'b0;
      pe_ready_load <= 1'b0;
      acc_valid     <= 1'b0;
    end else begin
      pe_ready_load <= buf_rd_en;
      if (accum) begin
        acc     <= acc + prod_ext;
        ret_cnt <= ret_nxt;
      end
      case (state)
        IDLE: if (start) begin
          acc     <= '0;
          ret_cnt <= '0;
          tap_cnt <= '0;
          if (num_taps == 8'd0) begin
            acc_valid <= 1'b1;
            state     <= DONE;
          end else begin
            n_lat     <= (num_taps > MAX_N) ? MAX_N : num_taps;
            buf_rd_en <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (8'(tap_cnt) == n_lat - 8'd1) begin
            buf_rd_en <= 1'b0;
            state     <= DRAIN;
          end else begin
            tap_cnt <= tap_cnt + ADDR_WIDTH'(1);
          end
        end
        DRAIN: if (ret_nxt >= n_lat) begin
          acc_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (acc_ready) begin
          acc_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_tap_sequencer.sv
// Directed bench for pe_tap_sequencer with operand buffer and PE models and a
// result scoreboard of expected sums and start-to-valid latencies.
module tb_pe_tap_sequencer;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        num_taps;
  logic              busy, buf_rd_en, pe_ready_load, acc_valid, acc_ready;
  logic [3:0]        buf_rd_addr;
  logic signed [7:0] ifm_rdata, wgt_rdata;
  logic [7:0]        pe_ifm, pe_wgt;
  logic signed [19:0] pe_product;
  logic              pe_ready_adder;
  logic signed [23:0] acc_out;

  logic signed [7:0] ifm_mem [16];
  logic signed [7:0] wgt_mem [16];
  wire  signed [15:0] p16 = $signed(pe_ifm) * $signed(pe_wgt);

  typedef struct { int sum; int lat; } exp_t;
  exp_t sb [$];
  int   total  = 0;
  int   passed = 0;
  int   fails  = 0;

  pe_tap_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .num_taps(num_taps), .busy(busy),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .ifm_rdata(ifm_rdata),
    .wgt_rdata(wgt_rdata), .pe_ready_load(pe_ready_load), .pe_ifm(pe_ifm),
    .pe_wgt(pe_wgt), .pe_product(pe_product), .pe_ready_adder(pe_ready_adder),
    .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready)
  );

  always #5 clk = ~clk;

  // Buffers return data one cycle after the read; the PE returns one cycle after load.
  always @(posedge clk) begin
    if (buf_rd_en) begin
      ifm_rdata <= ifm_mem[buf_rd_addr];
      wgt_rdata <= wgt_mem[buf_rd_addr];
    end
    pe_ready_adder <= pe_ready_load;
    if (pe_ready_load) pe_product <= {{4{p16[15]}}, p16};
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_const(input logic signed [7:0] a, input logic signed [7:0] b);
    for (int i = 0; i < 16; i++) begin ifm_mem[i] = a; wgt_mem[i] = b; end
  endtask

  task automatic fill_signed();
    fill_const(8'sd0, 8'sd0);
    ifm_mem[0] = -8'sd128; ifm_mem[1] = 8'sd127;  ifm_mem[2] = -8'sd1;
    wgt_mem[0] = -8'sd128; wgt_mem[1] = -8'sd128; wgt_mem[2] = 8'sd5;
  endtask

  // Called just after a negedge; pulses start, tracks reads, returns at the
  // negedge where acc_valid is first seen.
  task automatic run_window(input int n, input int exp_sum, input int exp_lat, input string tag);
    int   k, rds;
    exp_t e;
    sb.push_back('{exp_sum, exp_lat});
    start = 1'b1; num_taps = 8'(n);
    @(negedge clk); start = 1'b0;
    k = 1; rds = 0;
    while (!acc_valid && k < 100) begin
      if (buf_rd_en) begin
        check({tag, "_addr"}, int'(buf_rd_addr), rds);
        rds++;
      end
      @(negedge clk); k++;
    end
    check({tag, "_valid"}, int'(acc_valid), 1);
    check({tag, "_reads"}, rds, (n > 9) ? 9 : n);
    check({tag, "_sb_nonempty"}, int'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_latency"}, k, e.lat);
      check({tag, "_sum"}, int'(acc_out), e.sum);
    end
  endtask

  task automatic handshake(input string tag);
    acc_ready = 1'b1;
    @(negedge clk); acc_ready = 1'b0;
    check({tag, "_hs_valid"}, int'(acc_valid), 0);
    check({tag, "_hs_busy"}, int'(busy), 0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; num_taps = '0; acc_ready = 1'b0;
    ifm_rdata = '0; wgt_rdata = '0; pe_product = '0; pe_ready_adder = 1'b0;
    fill_const(8'sd2, 8'sd3);
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_rd_en", int'(buf_rd_en), 0);
    check("rst_addr", int'(buf_rd_addr), 0);
    check("rst_load", int'(pe_ready_load), 0);
    check("rst_acc", int'(acc_out), 0);
    check("rst_valid", int'(acc_valid), 0);
    rst = 1'b0;
    @(negedge clk);

    run_window(9, 54, 12, "basic");
    handshake("basic");

    @(negedge clk);
    fill_signed();
    run_window(3, 123, 6, "signed");
    for (int i = 0; i < 10; i++) begin
      start = (i == 3); num_taps = 8'd2;
      @(negedge clk);
      check("bp_acc_stable", int'(acc_out), 123);
      check("bp_busy", int'(busy), 1);
    end
    start = 1'b0;
    handshake("bp");
    seen = 0;
    repeat (8) begin @(negedge clk); if (busy || acc_valid) seen = 1; end
    check("bp_start_ignored", seen, 0);

    // Ready already high before the DONE entry edge must not complete a handshake.
    acc_ready = 1'b1;
    run_window(0, 0, 1, "n0");
    @(negedge clk); acc_ready = 1'b0;
    check("n0_hs_valid", int'(acc_valid), 0);
    check("n0_hs_busy", int'(busy), 0);

    fill_const(8'sd2, 8'sd3);
    run_window(1, 6, 4, "n1");
    handshake("n1");
    run_window(15, 54, 12, "clamp");
    handshake("clamp");

    start = 1'b1; num_taps = 8'd9;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_rd_en", int'(buf_rd_en), 0);
    check("abort_addr", int'(buf_rd_addr), 0);
    check("abort_load", int'(pe_ready_load), 0);
    check("abort_acc", int'(acc_out), 0);
    check("abort_valid", int'(acc_valid), 0);
    seen = 0;
    repeat (15) begin @(negedge clk); if (acc_valid) seen = 1; end
    check("abort_no_valid", seen, 0);
    fill_signed();
    run_window(3, 123, 6, "after_rst");
    handshake("after_rst");

    @(negedge clk);
    fill_const(8'sd2, 8'sd3);
    run_window(9, 54, 12, "b2b_first");
    handshake("b2b_first");
    fill_signed();
    run_window(3, 123, 6, "b2b_second");
    handshake("b2b_second");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
